pp_muldiv: RTL
==============

# pp_muldiv

Iterative multiply/divide unit for the RV32M operations, fed by the register file's two read ports and producing a write-back value for that file. It runs once per accepted request, with a fixed latency for every operation. While it runs, it holds busy so the issue logic stalls. On completion it presents result, destination register and a one-cycle regwrite strobe to the write-back path.

## Interface
- XLEN, 32: operand/result width; counter width is $clog2(XLEN)+1.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled at posedge; ignored while busy=1.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  operand A, from register-file rd1.
- rs2_val  in  XLEN  operand B, from register-file rd2.
- rd_in  in  5  destination register index.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse.
- regwrite  out  1  equals done; drives register-file regwrite.
- result  out  XLEN  operation result; held until the next completion or reset.
- rd_out  out  5  captured rd_in; held like result.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE→CALC on start.
  - CALC→FIX after the 32nd iteration.
  - FIX→DONE unconditionally.
  - DONE→IDLE unconditionally.
- On accept:
  - Capture op and rd_in.
  - Capture operand magnitudes and sign flags.
  - Signedness:
    - Operand A is signed for MUL, MULH, MULHSU, DIV and REM.
    - Operand B is signed for MUL, MULH, DIV and REM.
    - A magnitude of 0x80000000 is kept as unsigned 0x80000000.
- Multiply (CALC): unsigned shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator.
- Divide (CALC): restoring division, one quotient bit per cycle; 2·XLEN remainder/quotient register.
- FIX (multiply):
  - Negate the product if sign A ^ sign B (signed cases only).
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- FIX (divide):
  - Quotient sign is A^B.
  - Remainder sign follows A.
- Divide special cases, resolved in FIX (latency unchanged):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1_val.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- result and rd_out update only on the FIX→DONE edge.
- start while busy=1 is dropped, with no queuing.

## Timing
- Reset values: state IDLE, busy 0, done 0, regwrite 0, result 0, rd_out 0, counter 0.
- Start accepted at edge T0:
  - Iterations occur on edges T1..T32.
  - FIX occurs at edge T33.
  - done, regwrite, result and rd_out are valid during the cycle after T33.
  - Latency is 34 cycles, start edge to done, for all ops.
- Back-to-back operation:
  - A new start is accepted no earlier than edge T34, the DONE→IDLE edge, because busy is still 1 in DONE.
  - Minimum issue interval is 35 cycles.
- Operands must be stable at the accepting edge. The register file updates its read data on negedge, so this holds.
- rst on any edge, including mid-CALC or in DONE:
  - Returns the block to IDLE with all outputs at their reset values.
  - No done pulse is produced for the aborted operation.
- rst and start on the same edge: rst wins and the request is lost.

## Structure
- Package pp_muldiv_pkg holds:
  - Op localparams (OP_MUL..OP_REMU).
  - The state enum (IDLE, CALC, FIX, DONE).
  - LATENCY = 34.
  - XLEN default.
- Single module, with no sub-module. One shared XLEN+1-bit adder/subtractor serves both the multiply-accumulate and the trial subtraction.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → result 0xFFFFFFEB, done exactly 34 cycles after start, regwrite=1 for 1 cycle, rd_out=rd_in.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 0xFFFFFFFE / 2 → 0x7FFFFFFF.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF, REMU 5 / 0 → 5; overflow: DIV 0x80000000 / −1 → 0x80000000, REM → 0; both at 34-cycle latency.
- start re-asserted every cycle while busy → only the first and the post-DONE requests complete, 35 cycles apart; result held between completions.
- rst at cycle 10 of a DIV → busy and done drop next cycle, result=0, no regwrite; a fresh MUL 3×4 afterwards → 12.

Source files
------------

// File: rtl/pp_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM states, fixed latency and operand signedness helpers.
package pp_muldiv_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned LATENCY      = 34;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/pp_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, sign fix-up in FIX, one-cycle write-back strobe in DONE.
module pp_muldiv
   import pp_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic            regwrite,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int unsigned CW = $clog2(XLEN) + 1;

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     cnt;
   logic              last_iter;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic              sign_a;
   logic              sign_b;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_step;

   logic              in_sign_a;
   logic              in_sign_b;
   logic [XLEN-1:0]   in_mag_a;
   logic [XLEN-1:0]   in_mag_b;

   logic              is_div;
   logic              add_sub;
   logic [XLEN:0]     add_a;
   logic [XLEN:0]     add_b;
   logic [XLEN:0]     add_sum;
   logic              add_cout;

   logic              div0;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   a_orig;
   logic [2*XLEN-1:0] mul_prod;
   logic [XLEN-1:0]   fix_val;

   assign is_div    = op_q[2];
   assign last_iter = (cnt == CW'(XLEN - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (last_iter) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      regwrite = (state == DONE);
   end

   // Operand conditioning at accept; 0x80000000 negates to itself, read as unsigned.
   always_comb begin
      in_sign_a = a_is_signed(op) & rs1_val[XLEN-1];
      in_sign_b = b_is_signed(op) & rs2_val[XLEN-1];
      in_mag_a  = in_sign_a ? -rs1_val : rs1_val;
      in_mag_b  = in_sign_b ? -rs2_val : rs2_val;
   end

   // Shared adder: accumulate for multiply, trial subtract for divide.
   always_comb begin
      add_sub = is_div;
      add_a   = is_div ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
      add_b   = {1'b0, mag_b};
      {add_cout, add_sum} = {1'b0, add_a}
                          + {1'b0, (add_sub ? ~add_b : add_b)}
                          + {{(XLEN+1){1'b0}}, add_sub};
   end

   always_comb begin
      acc_step = acc;
      if (is_div) begin
         if (add_cout) begin
            acc_step = {add_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            acc_step = {acc[2*XLEN-2:0], 1'b0};
         end
      end else begin
         if (acc[0]) begin
            acc_step = {add_sum, acc[XLEN-1:1]};
         end else begin
            acc_step = {1'b0, acc[2*XLEN-1:1]};
         end
      end
   end

   // Signed overflow (MIN / -1) needs no override: |MIN|/1 negated wraps to MIN, remainder 0.
   always_comb begin
      div0     = (mag_b == '0);
      quot     = acc[XLEN-1:0];
      rem      = acc[2*XLEN-1:XLEN];
      a_orig   = sign_a ? -mag_a : mag_a;
      mul_prod = (sign_a ^ sign_b) ? -acc : acc;
      fix_val  = '0;
      case (op_q)
         OP_MUL:                        fix_val = mul_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = mul_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               fix_val = div0 ? '1 : ((sign_a ^ sign_b) ? -quot : quot);
         OP_REM, OP_REMU:               fix_val = div0 ? a_orig : (sign_a ? -rem : rem);
         default:                       fix_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         op_q   <= OP_MUL;
         rd_q   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         result <= '0;
         rd_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  op_q   <= op;
                  rd_q   <= rd_in;
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  mag_a  <= in_mag_a;
                  mag_b  <= in_mag_b;
                  acc    <= {{XLEN{1'b0}}, in_mag_a};
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               result <= fix_val;
               rd_out <= rd_q;
            end
            default: ;
         endcase
      end
   end

endmodule
